// File: rtl/memoria_be_dp.sv
// memoria_be_dp: simple-dual-port RAM with byte-lane writes and a registered read port.
// The read data is registered and comes with a valid pulse.
// A write and a read to the same address on the same edge return the newly written bytes (write-first).
// After reset, a sequencer can zero the whole array before the memory accepts requests.
// Optional feature: define MEMORIA_OUT_REG_EN to add an output register stage (read latency 2).
//
// state | meaning
// CLEAR | in reset or sweeping zeros; busy_o=1, requests ignored
// READY | normal read/write service
module memoria_be_dp #(
  parameter int ANCHO   = 32,
  parameter int PROF    = 10,
  parameter int LIMPIAR = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wren_i,
  input  logic [ANCHO/8-1:0] wrbe_i,
  input  logic [PROF-1:0]    wraddr_i,
  input  logic [ANCHO-1:0]   wrdata_i,
  input  logic               rden_i,
  input  logic [PROF-1:0]    rdaddr_i,
  output logic [ANCHO-1:0]   rddata_o,
  output logic               rdvalid_o,
  output logic               busy_o
);

  localparam int NB = ANCHO / 8;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state, state_d;
  logic [PROF-1:0]   clr_addr, clr_addr_d;
  logic [ANCHO-1:0]  mem [0:(1<<PROF)-1];

  logic              mem_we;
  logic [PROF-1:0]   mem_addr;
  logic [NB-1:0]     mem_be;
  logic [ANCHO-1:0]  mem_data;
  logic [ANCHO-1:0]  fwd;
  logic              collide;
  logic [ANCHO-1:0]  rd_d;
  logic              rd_v;

  // State, sweep pointer and busy flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy_o   <= 1'b1;
    end else begin
      state    <= state_d;
      clr_addr <= clr_addr_d;
      busy_o   <= (state_d == CLEAR);
    end
  end

  // Next state: sweep one word per cycle, or leave at once when clearing is disabled
  always_comb begin
    state_d    = state;
    clr_addr_d = clr_addr;
    if (state == CLEAR) begin
      if (LIMPIAR != 0) begin
        clr_addr_d = clr_addr + PROF'(1);
        if (&clr_addr) state_d = READY;
      end else begin
        state_d = READY;
      end
    end
  end

  // Single write port shared between the clear sweep and user writes
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wraddr_i;
    mem_be   = wrbe_i;
    mem_data = wrdata_i;
    if (!rst_i) begin
      if (state == CLEAR) begin
        if (LIMPIAR != 0) begin
          mem_we   = 1'b1;
          mem_addr = clr_addr;
          mem_be   = '1;
          mem_data = '0;
        end
      end else if (wren_i) begin
        mem_we = 1'b1;
      end
    end
  end

  // Byte-lane array write
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_data[8*k +: 8];
      end
    end
  end

  // Write-first merge: bytes being written on this edge override the stored word
  always_comb begin
    collide = (state == READY) && wren_i && (wraddr_i == rdaddr_i);
    fwd     = mem[rdaddr_i];
    for (int k = 0; k < NB; k++) begin
      if (collide && wrbe_i[k]) fwd[8*k +: 8] = wrdata_i[8*k +: 8];
    end
  end

  // Registered read stage; data holds when no read is issued
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_d <= '0;
      rd_v <= 1'b0;
    end else if (state == READY && rden_i) begin
      rd_d <= fwd;
      rd_v <= 1'b1;
    end else begin
      rd_v <= 1'b0;
    end
  end

`ifdef MEMORIA_OUT_REG_EN
  logic [ANCHO-1:0] out_d;
  logic             out_v;

  // Extra output stage: delays data and valid by one cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_d <= '0;
      out_v <= 1'b0;
    end else begin
      out_v <= rd_v;
      if (rd_v) out_d <= rd_d;
    end
  end

  assign rddata_o  = out_d;
  assign rdvalid_o = out_v;
`else
  assign rddata_o  = rd_d;
  assign rdvalid_o = rd_v;
`endif

endmodule

// File: tb/tb_memoria_be_dp.sv
// Self-checking bench for memoria_be_dp (ANCHO=32, PROF=4, LIMPIAR=1).
module tb_memoria_be_dp;

  localparam int DEPTH = 16;
`ifdef MEMORIA_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_i;
  logic        wren_i;
  logic [3:0]  wrbe_i;
  logic [3:0]  wraddr_i;
  logic [31:0] wrdata_i;
  logic        rden_i;
  logic [3:0]  rdaddr_i;
  logic [31:0] rddata_o;
  logic        rdvalid_o;
  logic        busy_o;

  memoria_be_dp #(.ANCHO(32), .PROF(4), .LIMPIAR(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .wren_i(wren_i), .wrbe_i(wrbe_i),
    .wraddr_i(wraddr_i), .wrdata_i(wrdata_i), .rden_i(rden_i),
    .rdaddr_i(rdaddr_i), .rddata_o(rddata_o), .rdvalid_o(rdvalid_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, busy flag, clear progress and read pipeline
  logic [31:0] mm [0:DEPTH-1];
  logic        mb;
  int          cnt;
  logic        pv [0:LAT-1];
  logic [31:0] pd [0:LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the current inputs to the model, advance one clock, then compare
  task automatic step();
    logic [31:0] rd;
    logic        nv;
    logic [31:0] nd;
    if (rst_i) begin
      mb  = 1'b1;
      cnt = 0;
      for (int i = 0; i < LAT; i++) begin
        pv[i] = 1'b0;
        pd[i] = '0;
      end
    end else begin
      nv = 1'b0;
      nd = pd[0];
      if (mb) begin
        cnt++;
        if (cnt == DEPTH) begin
          mb = 1'b0;
          for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        end
      end else begin
        if (rden_i) begin
          rd = mm[rdaddr_i];
          if (wren_i && wraddr_i == rdaddr_i)
            for (int k = 0; k < 4; k++) if (wrbe_i[k]) rd[8*k +: 8] = wrdata_i[8*k +: 8];
          nv = 1'b1;
          nd = rd;
        end
        if (wren_i)
          for (int k = 0; k < 4; k++) if (wrbe_i[k]) mm[wraddr_i][8*k +: 8] = wrdata_i[8*k +: 8];
      end
      for (int i = LAT - 1; i > 0; i--) begin
        if (pv[i-1]) pd[i] = pd[i-1];
        pv[i] = pv[i-1];
      end
      pv[0] = nv;
      pd[0] = nd;
    end
    @(posedge clk);
    #1;
    chk("busy", {31'b0, busy_o}, {31'b0, mb});
    chk("rdvalid", {31'b0, rdvalid_o}, {31'b0, pv[LAT-1]});
    chk("rddata", rddata_o, pd[LAT-1]);
  endtask

  task automatic idle();
    wren_i = 1'b0; rden_i = 1'b0; wrbe_i = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    wren_i = 1'b1; wraddr_i = a; wrbe_i = be; wrdata_i = d;
    step();
    idle();
  endtask

  task automatic read_lit(input string name, input logic [3:0] a, input logic [31:0] exp);
    rden_i = 1'b1; rdaddr_i = a;
    step();
    idle();
    for (int i = 1; i < LAT; i++) step();
    chk({name, "_valid"}, {31'b0, rdvalid_o}, 32'd1);
    chk(name, rddata_o, exp);
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (busy_o && n < 100) begin
      step();
      n++;
    end
    chk(name, n, exp_cycles);
  endtask

  initial begin
    int idx;
    rst_i = 1'b1; wren_i = 1'b0; wrbe_i = '0; wraddr_i = '0; wrdata_i = '0;
    rden_i = 1'b0; rdaddr_i = '0;
    mb = 1'b1; cnt = 0;
    for (int i = 0; i < DEPTH; i++) mm[i] = 'x;
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    @(negedge clk);

    // Reset state and clear length
    step();
    step();
    rst_i = 1'b0;
    wait_ready("clear_len", 16);
    read_lit("cleared_word", 4'd9, 32'h0);

    // Byte-enable merge
    wr(4'd3, 4'hF, 32'hDEADBEEF);
    wr(4'd3, 4'b0101, 32'h11223344);
    read_lit("be_merge", 4'd3, 32'hDE22BE44);

    // Write-first collision
    wr(4'd5, 4'hF, 32'hAAAAAAAA);
    wren_i = 1'b1; wraddr_i = 4'd5; wrbe_i = 4'b0011; wrdata_i = 32'h12345678;
    rden_i = 1'b1; rdaddr_i = 4'd5;
    step();
    idle();
    for (int i = 1; i < LAT; i++) step();
    chk("collision", rddata_o, 32'hAAAA5678);

    // Reset mid-clear restarts the sweep
    rst_i = 1'b1; step(); rst_i = 1'b0;
    repeat (7) step();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    wait_ready("restart_len", 16);

    // Requests while busy are ignored
    rst_i = 1'b1; step(); rst_i = 1'b0;
    wren_i = 1'b1; wraddr_i = 4'd0; wrbe_i = 4'hF; wrdata_i = 32'hFFFFFFFF;
    rden_i = 1'b1; rdaddr_i = 4'd0;
    step();
    idle();
    chk("busy_no_valid", {31'b0, rdvalid_o}, 32'd0);
    wait_ready("busy_rest", 15);
    read_lit("busy_write_dropped", 4'd0, 32'h0);

    // Back-to-back reads 0..3
    for (int i = 0; i < 4; i++) wr(4'(i), 4'hF, 32'h100 + 32'(i));
    idx = 0;
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i < 4) begin rden_i = 1'b1; rdaddr_i = 4'(i); end
      else idle();
      step();
      if (rdvalid_o) begin
        chk("b2b_data", rddata_o, 32'h100 + 32'(idx));
        chk("b2b_slot", i, idx + LAT - 1);
        idx++;
      end
    end
    chk("b2b_count", idx, 4);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rst_i    = ($urandom_range(0, 249) == 0);
      wren_i   = $urandom_range(0, 1) == 1;
      wrbe_i   = 4'($urandom);
      wraddr_i = 4'($urandom);
      wrdata_i = $urandom;
      rden_i   = $urandom_range(0, 2) != 0;
      rdaddr_i = ($urandom_range(0, 3) == 0) ? wraddr_i : 4'($urandom);
      step();
    end
    idle();
    rst_i = 1'b0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
